alu_issue: RTL
==============

# alu_issue

Decode/issue stage that feeds the integer ALU. Accepts fetched LA32R instructions with a valid/ready handshake, decodes the ALU subset, and reads two register-file operands. Emits a registered ALU bundle (opcode, two operands, destination) to the execute stage. A one-entry skid buffer gives a fully registered `if_ready` and lossless backpressure.

## Interface
- `WORD`, default 32: datapath width.
- `OPCODE_LEN`, default 4: ALU opcode width; must match the shared CPU parameter header.

- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `if_valid` in 1: fetch presents an instruction.
- `if_ready` out 1: stage can accept; equals `~skid_valid`.
- `if_inst` in 32: instruction word.
- `if_pc` in WORD: instruction PC.
- `rf_raddr0` out 5: combinational `if_inst[9:5]` (rj).
- `rf_raddr1` out 5: combinational `if_inst[14:10]` (rk).
- `rf_rdata0` in WORD: same-cycle read data for rj.
- `rf_rdata1` in WORD: same-cycle read data for rk.
- `flush` in 1: synchronous kill of all held instructions.
- `ex_valid` out 1: ALU bundle valid.
- `ex_ready` in 1: execute stage accepts the bundle.
- `ALU_opcode` out OPCODE_LEN: ALU operation code.
- `ALU_in0` out WORD: first ALU operand.
- `ALU_in1` out WORD: second ALU operand.
- `ex_rd` out 5: destination register.
- `ex_we` out 1: register write enable.
- `ex_pc` out WORD: PC of the issued instruction.
- `ex_illegal` out 1: instruction is not in the supported subset.

## Operation
- An input fires when `if_valid & if_ready`. Decode and register-file read happen in the fire cycle; the packed bundle is captured at that edge.
- Supported 3R ops (key `inst[31:15]`): add.w 0x00020, sub.w 0x00022, sltu 0x00025, and 0x00029, or 0x0002A, xor 0x0002B, sll.w 0x0002E, srl.w 0x0002F.
  - in0 = rj data, in1 = rk data.
- Supported shift-immediate ops (key `inst[31:15]`): slli.w 0x00081, srli.w 0x00089.
  - in1 = zero-extended ui5 (`inst[14:10]`).
- Supported 2RI12 ops (key `inst[31:22]`):
  - sltui 0x009 and addi.w 0x00A: in1 = sign-extended si12.
  - andi 0x00D, ori 0x00E, xori 0x00F: in1 = zero-extended ui12.
- Supported 1RI20 ops (key `inst[31:25]`): both use ALU_ADD with in1 = `{inst[24:5], 12'b0}`.
  - lu12i.w 0x0A: in0 = 0.
  - pcaddu12i 0x0E: in0 = `if_pc`.
- Field and write rules:
  - `ex_rd = inst[4:0]` for every instruction.
  - `ex_we = 1` only for a legal instruction with rd ≠ 0.
- Any other encoding: `ex_illegal = 1`, `ex_we = 0`, opcode ALU_ADD, in0 = in1 = 0.
- Output register (OR) loads a new bundle when it is empty or `ex_ready = 1`. The source is the skid bundle if `skid_valid`, otherwise the fired input.
- Skid buffer: a fired input is captured into the skid when `ex_valid & ~ex_ready`.
  - Skid drains into the OR on the next `ex_ready`.
  - Order is strictly preserved; no bundle is duplicated or dropped.
- Simultaneous drain and fire: the skid bundle moves to the OR and the fired bundle fills the skid. This cannot occur when `if_ready = 0`, because fire requires `if_ready`.
- `flush` has priority: at the edge, `ex_valid` and `skid_valid` clear and any input firing that cycle is discarded.
- Reset: `ex_valid`, `skid_valid`, and all bundle fields (including `ALU_opcode`) are 0. `if_ready` is 1 during and after reset.
- Register-file hazards are out of scope; upstream withholds `if_valid` until operands are current.

## Timing
- Latency: fire in cycle N gives `ex_valid` in cycle N+1 when the OR is free.
- `if_ready` is a register output. It deasserts the cycle after a skid capture and reasserts the cycle after the skid drains.
- While `ex_valid & ~ex_ready`, all `ex_*` and `ALU_*` outputs hold stable.
- Full sustained throughput: one instruction per cycle while `ex_ready = 1`.

## Structure
- The ALU opcode constants (ALU_ADD … ALU_SLTU), `OPCODE_LEN`, `WORD`, and the instruction-key constants above belong in the shared CPU parameter header.
- One sub-module, `la32_alu_decode`: purely combinational, mapping `inst`, `pc`, rdata0 and rdata1 to the bundle.
- The top level holds only the OR, the skid, and the handshake logic.

## Test plan
- add.w, inst 0x00100823, with r1 = 5 and r2 = 7 → next cycle `ex_valid = 1`, ALU_ADD, in0 = 5, in1 = 7, rd = 3, we = 1.
- addi.w, inst 0x02BFFC24, with r1 = 9 → in0 = 9, in1 = 0xFFFFFFFF, rd = 4.
- ori, inst 0x03BFFC05 → in1 = 0x00000FFF. lu12i.w, inst 0x15000006 → in0 = 0, in1 = 0x80000000.
- rd = 0 case: add.w rd = 0, inst 0x00100820 → `ex_we = 0`, `ex_illegal = 0`. Illegal case: 0xFFFFFFFF → `ex_illegal = 1`, `ex_we = 0`.
- Backpressure: `ex_ready = 0`, fire instructions A then B → `if_ready = 0` from the cycle after B fires. Then `ex_ready = 1` → A, then B, then fresh C are issued in order, one per cycle, with no loss.
- Flush with the OR and skid both full plus `if_valid = 1` → next cycle `ex_valid = 0` and `if_ready = 1`. Asserting `rstn = 0` mid-stream clears everything asynchronously.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared CPU parameters: datapath widths, ALU opcodes and LA32R instruction keys.
package alu_issue_pkg;

   localparam int unsigned CPU_WORD       = 32;
   localparam int unsigned CPU_OPCODE_LEN = 4;

   // ALU operation codes; ALU_ADD is zero so that reset and illegal bundles read as ADD.
   localparam logic [CPU_OPCODE_LEN-1:0] ALU_ADD  = 4'd0;
   localparam logic [CPU_OPCODE_LEN-1:0] ALU_SUB  = 4'd1;
   localparam logic [CPU_OPCODE_LEN-1:0] ALU_AND  = 4'd2;
   localparam logic [CPU_OPCODE_LEN-1:0] ALU_OR   = 4'd3;
   localparam logic [CPU_OPCODE_LEN-1:0] ALU_XOR  = 4'd4;
   localparam logic [CPU_OPCODE_LEN-1:0] ALU_SLL  = 4'd5;
   localparam logic [CPU_OPCODE_LEN-1:0] ALU_SRL  = 4'd6;
   localparam logic [CPU_OPCODE_LEN-1:0] ALU_SLTU = 4'd7;

   // 3R and shift-immediate keys, inst[31:15].
   localparam logic [16:0] KEY_ADD_W  = 17'h00020;
   localparam logic [16:0] KEY_SUB_W  = 17'h00022;
   localparam logic [16:0] KEY_SLTU   = 17'h00025;
   localparam logic [16:0] KEY_AND    = 17'h00029;
   localparam logic [16:0] KEY_OR     = 17'h0002A;
   localparam logic [16:0] KEY_XOR    = 17'h0002B;
   localparam logic [16:0] KEY_SLL_W  = 17'h0002E;
   localparam logic [16:0] KEY_SRL_W  = 17'h0002F;
   localparam logic [16:0] KEY_SLLI_W = 17'h00081;
   localparam logic [16:0] KEY_SRLI_W = 17'h00089;

   // 2RI12 keys, inst[31:22].
   localparam logic [9:0] KEY_SLTUI  = 10'h009;
   localparam logic [9:0] KEY_ADDI_W = 10'h00A;
   localparam logic [9:0] KEY_ANDI   = 10'h00D;
   localparam logic [9:0] KEY_ORI    = 10'h00E;
   localparam logic [9:0] KEY_XORI   = 10'h00F;

   // 1RI20 keys, inst[31:25].
   localparam logic [6:0] KEY_LU12I_W   = 7'h0A;
   localparam logic [6:0] KEY_PCADDU12I = 7'h0E;

   // Operand source class selected by the decoder.
   typedef enum logic [2:0] {
      SrcIll,
      SrcRR,
      SrcUi5,
      SrcSi12,
      SrcUi12,
      SrcLu12i,
      SrcPcadd
   } src_e;

endpackage

// File: rtl/la32_alu_decode.sv
// Combinational LA32R ALU-subset decoder: instruction, PC and operands to an ALU bundle.
module la32_alu_decode
   import alu_issue_pkg::*;
#(
   parameter int unsigned WORD       = CPU_WORD,
   parameter int unsigned OPCODE_LEN = CPU_OPCODE_LEN
) (
   input  logic [31:0]           inst_i,
   input  logic [WORD-1:0]       pc_i,
   input  logic [WORD-1:0]       rdata0_i,
   input  logic [WORD-1:0]       rdata1_i,
   output logic [OPCODE_LEN-1:0] opcode_o,
   output logic [WORD-1:0]       in0_o,
   output logic [WORD-1:0]       in1_o,
   output logic [4:0]            rd_o,
   output logic                  we_o,
   output logic                  illegal_o
);

   src_e                      src;
   logic [CPU_OPCODE_LEN-1:0] opc;

   // Key match: the three key fields never alias, so the first hit wins.
   always_comb begin
      src = SrcIll;
      opc = ALU_ADD;
      unique case (inst_i[31:15])
         KEY_ADD_W:  begin src = SrcRR;  opc = ALU_ADD;  end
         KEY_SUB_W:  begin src = SrcRR;  opc = ALU_SUB;  end
         KEY_SLTU:   begin src = SrcRR;  opc = ALU_SLTU; end
         KEY_AND:    begin src = SrcRR;  opc = ALU_AND;  end
         KEY_OR:     begin src = SrcRR;  opc = ALU_OR;   end
         KEY_XOR:    begin src = SrcRR;  opc = ALU_XOR;  end
         KEY_SLL_W:  begin src = SrcRR;  opc = ALU_SLL;  end
         KEY_SRL_W:  begin src = SrcRR;  opc = ALU_SRL;  end
         KEY_SLLI_W: begin src = SrcUi5; opc = ALU_SLL;  end
         KEY_SRLI_W: begin src = SrcUi5; opc = ALU_SRL;  end
         default: ;
      endcase
      if (src == SrcIll) begin
         unique case (inst_i[31:22])
            KEY_SLTUI:  begin src = SrcSi12; opc = ALU_SLTU; end
            KEY_ADDI_W: begin src = SrcSi12; opc = ALU_ADD;  end
            KEY_ANDI:   begin src = SrcUi12; opc = ALU_AND;  end
            KEY_ORI:    begin src = SrcUi12; opc = ALU_OR;   end
            KEY_XORI:   begin src = SrcUi12; opc = ALU_XOR;  end
            default: ;
         endcase
      end
      if (src == SrcIll) begin
         unique case (inst_i[31:25])
            KEY_LU12I_W:   begin src = SrcLu12i; opc = ALU_ADD; end
            KEY_PCADDU12I: begin src = SrcPcadd; opc = ALU_ADD; end
            default: ;
         endcase
      end
   end

   // Operand selection per source class; illegal encodings yield zero operands.
   always_comb begin
      in0_o = '0;
      in1_o = '0;
      unique case (src)
         SrcRR:    begin in0_o = rdata0_i; in1_o = rdata1_i; end
         SrcUi5:   begin in0_o = rdata0_i; in1_o = {{(WORD-5){1'b0}}, inst_i[14:10]}; end
         SrcSi12:  begin in0_o = rdata0_i; in1_o = {{(WORD-12){inst_i[21]}}, inst_i[21:10]}; end
         SrcUi12:  begin in0_o = rdata0_i; in1_o = {{(WORD-12){1'b0}}, inst_i[21:10]}; end
         SrcLu12i: begin in0_o = '0;       in1_o = WORD'({inst_i[24:5], 12'b0}); end
         SrcPcadd: begin in0_o = pc_i;     in1_o = WORD'({inst_i[24:5], 12'b0}); end
         default: ;
      endcase
   end

   assign opcode_o  = OPCODE_LEN'(opc);
   assign rd_o      = inst_i[4:0];
   assign illegal_o = (src == SrcIll);
   assign we_o      = (src != SrcIll) && (inst_i[4:0] != 5'd0);

endmodule

// File: rtl/alu_issue.sv
// ALU decode/issue stage: output register plus one-entry skid buffer behind a
// fully registered if_ready.
module alu_issue
   import alu_issue_pkg::*;
#(
   parameter int unsigned WORD       = CPU_WORD,
   parameter int unsigned OPCODE_LEN = CPU_OPCODE_LEN
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  if_valid,
   output logic                  if_ready,
   input  logic [31:0]           if_inst,
   input  logic [WORD-1:0]       if_pc,
   output logic [4:0]            rf_raddr0,
   output logic [4:0]            rf_raddr1,
   input  logic [WORD-1:0]       rf_rdata0,
   input  logic [WORD-1:0]       rf_rdata1,
   input  logic                  flush,
   output logic                  ex_valid,
   input  logic                  ex_ready,
   output logic [OPCODE_LEN-1:0] ALU_opcode,
   output logic [WORD-1:0]       ALU_in0,
   output logic [WORD-1:0]       ALU_in1,
   output logic [4:0]            ex_rd,
   output logic                  ex_we,
   output logic [WORD-1:0]       ex_pc,
   output logic                  ex_illegal
);

   typedef struct packed {
      logic [OPCODE_LEN-1:0] opcode;
      logic [WORD-1:0]       in0;
      logic [WORD-1:0]       in1;
      logic [4:0]            rd;
      logic                  we;
      logic [WORD-1:0]       pc;
      logic                  illegal;
   } bundle_t;

   bundle_t dec_b;
   bundle_t or_q, or_d;
   bundle_t skid_q, skid_d;
   logic    ex_valid_q, ex_valid_d;
   logic    skid_valid_q, skid_valid_d;
   logic    fire;
   logic    or_free;

   assign rf_raddr0 = if_inst[9:5];
   assign rf_raddr1 = if_inst[14:10];

   la32_alu_decode #(
      .WORD       (WORD),
      .OPCODE_LEN (OPCODE_LEN)
   ) u_decode (
      .inst_i    (if_inst),
      .pc_i      (if_pc),
      .rdata0_i  (rf_rdata0),
      .rdata1_i  (rf_rdata1),
      .opcode_o  (dec_b.opcode),
      .in0_o     (dec_b.in0),
      .in1_o     (dec_b.in1),
      .rd_o      (dec_b.rd),
      .we_o      (dec_b.we),
      .illegal_o (dec_b.illegal)
   );
   assign dec_b.pc = if_pc;

   assign if_ready = ~skid_valid_q;
   assign fire     = if_valid & if_ready;
   assign or_free  = ~ex_valid_q | ex_ready;

   // Handshake: OR refills from the skid first, else from the fired input; a fire
   // while the OR is stalled parks in the skid.
   always_comb begin
      or_d         = or_q;
      skid_d       = skid_q;
      ex_valid_d   = ex_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         ex_valid_d   = 1'b0;
         skid_valid_d = 1'b0;
      end else if (or_free) begin
         if (skid_valid_q) begin
            or_d       = skid_q;
            ex_valid_d = 1'b1;
         end else begin
            ex_valid_d = fire;
            if (fire) begin
               or_d = dec_b;
            end
         end
         // Drain-and-fire refills the skid; unreachable while if_ready tracks skid.
         skid_valid_d = skid_valid_q & fire;
         if (skid_valid_q & fire) begin
            skid_d = dec_b;
         end
      end else if (fire) begin
         skid_d       = dec_b;
         skid_valid_d = 1'b1;
      end
   end

   // State registers with asynchronous clear of valids and bundle contents.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         or_q         <= '0;
         skid_q       <= '0;
         ex_valid_q   <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         or_q         <= or_d;
         skid_q       <= skid_d;
         ex_valid_q   <= ex_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign ex_valid   = ex_valid_q;
   assign ALU_opcode = or_q.opcode;
   assign ALU_in0    = or_q.in0;
   assign ALU_in1    = or_q.in1;
   assign ex_rd      = or_q.rd;
   assign ex_we      = or_q.we;
   assign ex_pc      = or_q.pc;
   assign ex_illegal = or_q.illegal;

endmodule
